// File: rtl/clock_timebase_pkg.sv
// Shared constants, mode encoding and helpers for the clock timebase.
package clock_timebase_pkg;

  // 1 ms terminal count for a 100 MHz reference clock
  localparam int unsigned DEFAULT_LIMIT_100MHZ_MS = 99999;

  // Every stage count is reported in a 4-bit slice, zero-extended
  localparam int unsigned STAGE_CNT_W = 4;

  // Decoded operating mode; the order of the decode is the control priority
  typedef enum logic [1:0] {
    MODE_CLEAR = 2'd0,  // i_enable low: synchronous clear
    MODE_PAUSE = 2'd1,  // i_pause high: hold everything, no pulses
    MODE_RUN   = 2'd2   // normal counting
  } tb_mode_e;

  // LSB position of stage k inside the packed o_stage_cnt bus
  function automatic int unsigned stage_lsb(input int unsigned k);
    return k * STAGE_CNT_W;
  endfunction

endpackage

// File: rtl/clock_timebase_if.sv
// Control and status bundle of the clock timebase.
// Handshake: there is no valid/ready pair; i_limit_wr is a single-cycle
// write strobe sampled on every rising i_clk edge, and all outputs are
// level signals valid for the whole cycle (pulses are one cycle wide).
interface clock_timebase_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_STAGES = 4
);
  import clock_timebase_pkg::*;

  logic                            i_enable;
  logic                            i_pause;
  logic                            i_limit_wr;
  logic [WIDTH-1:0]                i_limit;
  logic [WIDTH-1:0]                o_count;
  logic                            o_tick;
  logic [N_STAGES-1:0]             o_stage_pulse;
  logic [STAGE_CNT_W*N_STAGES-1:0] o_stage_cnt;

  // Controller side: drives controls, observes status
  modport master (
    output i_enable, i_pause, i_limit_wr, i_limit,
    input  o_count, o_tick, o_stage_pulse, o_stage_cnt
  );

  // Timebase side
  modport slave (
    input  i_enable, i_pause, i_limit_wr, i_limit,
    output o_count, o_tick, o_stage_pulse, o_stage_cnt
  );

endinterface

// File: rtl/clock_timebase_mod_n_counter.sv
// Modulo-MOD counter stage with clear, hold and increment-enable.
// o_wrap is combinational and high in the cycle the counter rolls to 0.
module mod_n_counter #(
  parameter int unsigned MOD = 10,
  parameter int unsigned W   = 4
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_clr,
  input  logic         i_hold,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] cnt_q;
  logic         at_top;

  assign at_top = (cnt_q == W'(MOD - 1));
  assign o_wrap = i_inc & ~i_hold & ~i_clr & at_top;
  assign o_cnt  = cnt_q;

  // Stage register: clear beats hold beats increment
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (!i_hold && i_inc) begin
      cnt_q <= at_top ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/clock_timebase.sv
// Timebase generator: programmable prescaler producing o_tick, followed by
// a cascade of modulo stages that divide the tick into slower pulses.
module clock_timebase
  import clock_timebase_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEFAULT_LIMIT = DEFAULT_LIMIT_100MHZ_MS,
  parameter int unsigned N_STAGES      = 4,
  parameter int unsigned STAGE_MOD     = 10
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  clock_timebase_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic             at_limit;
  logic             tick;
  logic             clr;
  logic             hold;
  tb_mode_e         mode;

  // Decode control priority: disable clears, then pause holds, else run
  always_comb begin
    mode = MODE_RUN;
    if (!bus.i_enable) begin
      mode = MODE_CLEAR;
    end else if (bus.i_pause) begin
      mode = MODE_PAUSE;
    end
  end

  assign clr  = (mode == MODE_CLEAR);
  assign hold = (mode == MODE_PAUSE);

  // >= so a limit lowered below the running count wraps on the next edge
  assign at_limit = (count_q >= limit_q);
  assign tick     = (mode == MODE_RUN) & at_limit;

  // Limit register: writes land regardless of enable/pause
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      limit_q <= WIDTH'(DEFAULT_LIMIT);
    end else if (bus.i_limit_wr) begin
      limit_q <= bus.i_limit;
    end
  end

  // Prescaler: wraps at the limit, so the plain add never overflows
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_q <= '0;
    end else begin
      case (mode)
        MODE_CLEAR: count_q <= '0;
        MODE_PAUSE: count_q <= count_q;
        default:    count_q <= at_limit ? '0 : count_q + WIDTH'(1);
      endcase
    end
  end

  assign bus.o_count = count_q;
  assign bus.o_tick  = tick;

  // Divide chain: stage 0 counts ticks, stage k counts wraps of stage k-1
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    localparam int unsigned LSB = stage_lsb(k);

    logic                   inc;
    logic                   wrap;
    logic [STAGE_CNT_W-1:0] cnt;

    if (k == 0) begin : g_first
      assign inc = tick;
    end else begin : g_next
      assign inc = g_stage[k-1].wrap;
    end

    mod_n_counter #(
      .MOD (STAGE_MOD),
      .W   (STAGE_CNT_W)
    ) u_stage (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_clr  (clr),
      .i_hold (hold),
      .i_inc  (inc),
      .o_cnt  (cnt),
      .o_wrap (wrap)
    );

    assign bus.o_stage_pulse[k]                 = wrap;
    assign bus.o_stage_cnt[LSB +: STAGE_CNT_W]  = cnt;
  end

endmodule
